// File: rtl/ram_arbiter.sv
// ram_arbiter
// Two-port arbiter and sequencer for the IO-block scratch RAM. One granted
// request at a time is turned into the RAM's latch-addressed bus sequence:
// a low-address latch cycle, a high-address latch cycle, a data cycle, and
// a one-cycle ack.
//
// Ports
//   wb_clk_i         system clock, rising edge
//   rst              synchronous active-high reset
//   req0/req1        requests, held high until the matching ack
//   we0/we1          1 = write, 0 = read (sampled at grant)
//   addr0/addr1      16-bit byte address (sampled at grant)
//   wdata0/wdata1    write data (sampled at grant)
//   ack0/ack1        one-cycle completion pulses
//   rdata            read data, valid from the ack cycle until next completion
//   busy             high whenever the FSM is not IDLE
//   ram_enabled      RAM enable, low only in reset
//   le_lo_act        RAM low-address latch strobe
//   le_hi_act        RAM high-address latch strobe
//   WEb_raw          RAM write strobe, active low
//   ram_bus_in       byte driven to the RAM bus
//   ram_bus_out      RAM read data (combinational from its latched address)
//
// Build option
//   RAM_ARB_ROUNDROBIN_EN  when defined, simultaneous requests alternate
//                          using a last-grant register; otherwise port 0
//                          has fixed priority.
module ram_arbiter (
    input  logic        wb_clk_i,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [15:0] addr0,
    input  logic [15:0] addr1,
    input  logic [7:0]  wdata0,
    input  logic [7:0]  wdata1,
    output logic        ack0,
    output logic        ack1,
    output logic [7:0]  rdata,
    output logic        busy,
    output logic        ram_enabled,
    output logic        le_lo_act,
    output logic        le_hi_act,
    output logic        WEb_raw,
    output logic [7:0]  ram_bus_in,
    input  logic [7:0]  ram_bus_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LO,
        S_HI,
        S_DATA,
        S_DONE
    } state_e;

    state_e      state_q, state_d;
    logic        port_q, port_d;      // granted port: 0 or 1
    logic        we_q, we_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  bus_q, bus_d;        // ram_bus_in holds its value between strobes
    logic [7:0]  rdata_q, rdata_d;
    logic        en_q;
    logic        grant1;              // winner of arbitration in IDLE is port 1

`ifdef RAM_ARB_ROUNDROBIN_EN
    logic        last_q, last_d;

    // Only a true collision consults history; a lone requester always wins.
    always_comb begin
        if (req0 && req1) grant1 = ~last_q;
        else              grant1 = ~req0;
    end
`else
    always_comb begin
        grant1 = ~req0;
    end
`endif

    always_ff @(posedge wb_clk_i) begin
        if (rst) begin
            state_q <= S_IDLE;
            port_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 16'h0000;
            wdata_q <= 8'h00;
            bus_q   <= 8'h00;
            rdata_q <= 8'h00;
            en_q    <= 1'b0;
`ifdef RAM_ARB_ROUNDROBIN_EN
            last_q  <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            port_q  <= port_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            bus_q   <= bus_d;
            rdata_q <= rdata_d;
            en_q    <= 1'b1;
`ifdef RAM_ARB_ROUNDROBIN_EN
            last_q  <= last_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        port_d    = port_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        bus_d     = bus_q;
        rdata_d   = rdata_q;
        le_lo_act = 1'b0;
        le_hi_act = 1'b0;
        WEb_raw   = 1'b1;
`ifdef RAM_ARB_ROUNDROBIN_EN
        last_d    = last_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    port_d  = grant1;
                    we_d    = grant1 ? we1    : we0;
                    addr_d  = grant1 ? addr1  : addr0;
                    wdata_d = grant1 ? wdata1 : wdata0;
                    // Bus is loaded on the grant edge so it is stable for the
                    // whole LO cycle.
                    bus_d   = grant1 ? addr1[7:0] : addr0[7:0];
                    state_d = S_LO;
`ifdef RAM_ARB_ROUNDROBIN_EN
                    last_d  = grant1;
`endif
                end
            end
            S_LO: begin
                le_lo_act = 1'b1;
                bus_d     = addr_q[15:8];
                state_d   = S_HI;
            end
            S_HI: begin
                le_hi_act = 1'b1;
                // Reads leave the high address on the bus during DATA.
                if (we_q) bus_d = wdata_q;
                state_d = S_DATA;
            end
            S_DATA: begin
                WEb_raw = ~we_q;
                if (!we_q) rdata_d = ram_bus_out;
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign ack0        = (state_q == S_DONE) && !port_q;
    assign ack1        = (state_q == S_DONE) &&  port_q;
    assign busy        = (state_q != S_IDLE);
    assign rdata       = rdata_q;
    assign ram_bus_in  = bus_q;
    assign ram_enabled = en_q;

endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;

    logic        wb_clk_i = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [15:0] addr0 = 16'h0, addr1 = 16'h0;
    logic [7:0]  wdata0 = 8'h0, wdata1 = 8'h0;
    logic        ack0, ack1, busy, ram_enabled, le_lo_act, le_hi_act, WEb_raw;
    logic [7:0]  rdata, ram_bus_in, ram_bus_out;

    ram_arbiter dut (
        .wb_clk_i(wb_clk_i), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy),
        .ram_enabled(ram_enabled), .le_lo_act(le_lo_act), .le_hi_act(le_hi_act),
        .WEb_raw(WEb_raw), .ram_bus_in(ram_bus_in), .ram_bus_out(ram_bus_out)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int cyc = 0;
    always @(posedge wb_clk_i) cyc <= cyc + 1;

    // RAM model: 4 KiB behind a latch-addressed bus; addresses >= 0x1000 are
    // not backed (writes dropped, reads 0x00).
    logic [7:0]  mem [0:4095];
    logic [15:0] lat = 16'h0;
    initial for (int i = 0; i < 4096; i++) mem[i] = i[7:0] ^ 8'h3C;
    always @(posedge wb_clk_i) begin
        if (ram_enabled) begin
            if (le_lo_act) lat[7:0]  <= ram_bus_in;
            if (le_hi_act) lat[15:8] <= ram_bus_in;
            if (!WEb_raw && lat < 16'h1000) mem[lat[11:0]] <= ram_bus_in;
        end
    end
    assign ram_bus_out = (lat < 16'h1000) ? mem[lat[11:0]] : 8'h00;

    typedef struct { logic we; logic [15:0] addr; logic [7:0] wdata; } txn_t;
    typedef struct { bit port; bit chk; logic [7:0] data; int cyc; } exp_t;

    txn_t tx0[$], tx1[$];
    exp_t sb[$];
    int   n_cmp = 0, n_err = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    task automatic push_exp(input bit p, input bit chk, input logic [7:0] d, input int c);
        exp_t e;
        e.port = p; e.chk = chk; e.data = d; e.cyc = c;
        sb.push_back(e);
    endtask

    task automatic add_txn(input bit p, input logic w, input logic [15:0] a, input logic [7:0] d);
        txn_t t;
        t.we = w; t.addr = a; t.wdata = d;
        if (p) tx1.push_back(t); else tx0.push_back(t);
    endtask

    task automatic set_port(input bit p, input logic r, input txn_t t);
        if (p) begin req1 = r; we1 = t.we; addr1 = t.addr; wdata1 = t.wdata; end
        else   begin req0 = r; we0 = t.we; addr0 = t.addr; wdata0 = t.wdata; end
    endtask

    task automatic sync();
        @(posedge wb_clk_i); #1;
    endtask

    // Requester: keeps req high across n transactions, presenting the next
    // one on the edge that ends each ack cycle, and drops req after the last.
    task automatic drive(input bit p, input int n);
        txn_t t;
        int   got = 0;
        int   budget = 200;
        if (p) t = tx1.pop_front(); else t = tx0.pop_front();
        set_port(p, 1'b1, t);
        while (got < n && budget > 0) begin
            @(negedge wb_clk_i);
            budget--;
            if (p ? ack1 : ack0) begin
                got++;
                @(posedge wb_clk_i); #1;
                if (got < n) begin
                    if (p) t = tx1.pop_front(); else t = tx0.pop_front();
                    set_port(p, 1'b1, t);
                end else begin
                    set_port(p, 1'b0, t);
                end
            end
        end
        if (got < n) begin
            n_cmp++; n_err++;
            $display("FAIL ack_timeout port%0d: got %0d acks expected %0d", p, got, n);
            set_port(p, 1'b0, t);
        end
    endtask

    // Monitor: every ack is matched against the oldest expectation.
    always @(negedge wb_clk_i) begin
        if (ack0 || ack1) begin
            if (sb.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL unexpected_ack: ack0=%0b ack1=%0b expected none (cycle %0d)", ack0, ack1, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("ack_port", {31'd0, ack1}, {31'd0, e.port});
                check("ack_both", {31'd0, ack0 & ack1}, 32'd0);
                check("ack_cycle", cyc, e.cyc);
                if (e.chk) check("rdata", {24'd0, rdata}, {24'd0, e.data});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   base;
        txn_t t;

        // Reset values.
        repeat (3) @(posedge wb_clk_i);
        #1;
        check("rst_ack0", {31'd0, ack0}, 32'd0);
        check("rst_ack1", {31'd0, ack1}, 32'd0);
        check("rst_rdata", {24'd0, rdata}, 32'h00);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ram_en", {31'd0, ram_enabled}, 32'd0);
        check("rst_le_lo", {31'd0, le_lo_act}, 32'd0);
        check("rst_le_hi", {31'd0, le_hi_act}, 32'd0);
        check("rst_web", {31'd0, WEb_raw}, 32'd1);
        check("rst_bus", {24'd0, ram_bus_in}, 32'h00);
        rst = 1'b0;
        sync();
        check("ram_en_after_rst", {31'd0, ram_enabled}, 32'd1);

        // Port 0 write 0x0123 <= 0xA5, bus sequence checked cycle by cycle.
        sync();
        base = cyc;
        push_exp(1'b0, 1'b0, 8'h00, base + 4);
        add_txn(1'b0, 1'b1, 16'h0123, 8'hA5);
        fork
            drive(1'b0, 1);
            begin
                @(negedge wb_clk_i);
                check("c0_busy", {31'd0, busy}, 32'd0);
                @(negedge wb_clk_i);
                check("c1_le_lo", {31'd0, le_lo_act}, 32'd1);
                check("c1_bus", {24'd0, ram_bus_in}, 32'h23);
                check("c1_busy", {31'd0, busy}, 32'd1);
                @(negedge wb_clk_i);
                check("c2_le_hi", {31'd0, le_hi_act}, 32'd1);
                check("c2_le_lo", {31'd0, le_lo_act}, 32'd0);
                check("c2_bus", {24'd0, ram_bus_in}, 32'h01);
                @(negedge wb_clk_i);
                check("c3_web", {31'd0, WEb_raw}, 32'd0);
                check("c3_bus", {24'd0, ram_bus_in}, 32'hA5);
                check("c3_le_hi", {31'd0, le_hi_act}, 32'd0);
            end
        join

        // Port 1 reads the byte back.
        sync();
        base = cyc;
        push_exp(1'b1, 1'b1, 8'hA5, base + 4);
        add_txn(1'b1, 1'b0, 16'h0123, 8'h00);
        drive(1'b1, 1);

        // Simultaneous requests: port 0 first, port 1 in the next IDLE.
        sync();
        base = cyc;
        push_exp(1'b0, 1'b1, 8'h2C, base + 4);
        push_exp(1'b1, 1'b1, 8'h2D, base + 9);
        add_txn(1'b0, 1'b0, 16'h0010, 8'h00);
        add_txn(1'b1, 1'b0, 16'h0011, 8'h00);
        fork
            drive(1'b0, 1);
            drive(1'b1, 1);
        join

        // Both ports hold req across two transactions each.
        sync();
        base = cyc;
`ifdef RAM_ARB_ROUNDROBIN_EN
        push_exp(1'b0, 1'b1, 8'h1C, base + 4);
        push_exp(1'b1, 1'b1, 8'h0C, base + 9);
        push_exp(1'b0, 1'b1, 8'h1D, base + 14);
        push_exp(1'b1, 1'b1, 8'h0D, base + 19);
`else
        push_exp(1'b0, 1'b1, 8'h1C, base + 4);
        push_exp(1'b0, 1'b1, 8'h1D, base + 9);
        push_exp(1'b1, 1'b1, 8'h0C, base + 14);
        push_exp(1'b1, 1'b1, 8'h0D, base + 19);
`endif
        add_txn(1'b0, 1'b0, 16'h0020, 8'h00);
        add_txn(1'b0, 1'b0, 16'h0021, 8'h00);
        add_txn(1'b1, 1'b0, 16'h0030, 8'h00);
        add_txn(1'b1, 1'b0, 16'h0031, 8'h00);
        fork
            drive(1'b0, 2);
            drive(1'b1, 2);
        join

        // Unbacked address: write then read 0x1000, then 0x0000 is intact.
        sync();
        base = cyc;
        push_exp(1'b1, 1'b0, 8'h00, base + 4);
        push_exp(1'b1, 1'b1, 8'h00, base + 9);
        push_exp(1'b1, 1'b1, 8'h3C, base + 14);
        add_txn(1'b1, 1'b1, 16'h1000, 8'h5A);
        add_txn(1'b1, 1'b0, 16'h1000, 8'h00);
        add_txn(1'b1, 1'b0, 16'h0000, 8'h00);
        drive(1'b1, 3);

        // Reset during HI of a write to 0x0040: aborted, no ack, RAM untouched.
        sync();
        t.we = 1'b1; t.addr = 16'h0040; t.wdata = 8'hFF;
        set_port(1'b0, 1'b1, t);
        repeat (3) @(negedge wb_clk_i);
        check("abort_in_hi", {31'd0, le_hi_act}, 32'd1);
        rst = 1'b1;
        @(posedge wb_clk_i); #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_web", {31'd0, WEb_raw}, 32'd1);
        check("abort_le_lo", {31'd0, le_lo_act}, 32'd0);
        check("abort_le_hi", {31'd0, le_hi_act}, 32'd0);
        check("abort_ack0", {31'd0, ack0}, 32'd0);
        set_port(1'b0, 1'b0, t);
        sync();
        rst = 1'b0;
        repeat (3) sync();
        base = cyc;
        push_exp(1'b1, 1'b1, 8'h7C, base + 4);
        add_txn(1'b1, 1'b0, 16'h0040, 8'h00);
        drive(1'b1, 1);

        // Port 0 back-to-back reads with req held high.
        sync();
        base = cyc;
        push_exp(1'b0, 1'b1, 8'h2C, base + 4);
        push_exp(1'b0, 1'b1, 8'h2D, base + 9);
        push_exp(1'b0, 1'b1, 8'h2E, base + 14);
        add_txn(1'b0, 1'b0, 16'h0010, 8'h00);
        add_txn(1'b0, 1'b0, 16'h0011, 8'h00);
        add_txn(1'b0, 1'b0, 16'h0012, 8'h00);
        drive(1'b0, 3);

        repeat (4) sync();
        check("sb_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
